// File: rtl/adc_dual_capture.sv
// adc_dual_capture: drives two serial 12-bit ADCs that share chip-select and
// serial clock, captures both data lines in the same frame, and presents the
// pair as a_out/b_out with a one-cycle valid strobe.
//
// Optional build macro ADC_AVG4_EN: when defined, four consecutive frames are
// summed per channel and valid pulses only on every fourth frame, carrying
// the truncated average. When undefined, every frame updates the outputs.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cs_n high, sclk high, waiting for start
// SETUP | cs_n low, sclk held high for one half-period
// SHIFT | sclk toggles; both data lines sampled on each rising edge
// HOLD  | sclk high for one half-period after the last edge; outputs load
// QUIET | cs_n high for QUIET_HALVES half-periods before the next frame

module adc_dual_capture #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = 16,
  parameter int QUIET_HALVES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_sdata_a,
  input  logic        adc_sdata_b,
  output logic [11:0] a_out,
  output logic [11:0] b_out,
  output logic        valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_QUIET
  } state_t;

  // One counter serves both the frame bit count and the quiet half count.
  localparam int CNT_MAX = (FRAME_BITS > QUIET_HALVES) ? FRAME_BITS : QUIET_HALVES;
  localparam int BW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] QUIET_LAST = BW'(QUIET_HALVES - 1);

  state_t        state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          valid_q, valid_d;
  logic [11:0]   a_out_q, a_out_d;
  logic [11:0]   b_out_q, b_out_d;

  // Only the last 12 bits of a frame are kept; the leading bits fall off the
  // top of these registers as the frame shifts through.
  logic [11:0]   sh_a_q, sh_a_d;
  logic [11:0]   sh_b_q, sh_b_d;

  logic          div_last;
  logic          load;

`ifdef ADC_AVG4_EN
  logic [13:0]   acc_a_q, acc_a_d;
  logic [13:0]   acc_b_q, acc_b_d;
  logic [1:0]    frm_q, frm_d;
  logic [13:0]   sum_a, sum_b;
`endif

  assign div_last = (div_q == DIV_LAST);

  // Frame sequencing: state, half-period timing, sclk/cs_n generation, shifting.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    overrun_d = overrun_q | (start & busy_q);
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = 8'd0;
          cnt_d   = '0;
        end
      end

      S_SETUP: begin
        if (div_last) begin
          div_d   = 8'd0;
          sclk_d  = 1'b0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT: begin
        if (div_last) begin
          div_d = 8'd0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            sh_a_d = {sh_a_q[10:0], adc_sdata_a};
            sh_b_d = {sh_b_q[10:0], adc_sdata_b};
            if (cnt_q == BIT_LAST) begin
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              cnt_d = cnt_q + BW'(1);
            end
          end else begin
            sclk_d = 1'b0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_HOLD: begin
        // The shift registers hold the full frame on the first HOLD cycle.
        load = (div_q == 8'd0);
        if (div_last) begin
          div_d   = 8'd0;
          cs_n_d  = 1'b1;
          state_d = S_QUIET;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_QUIET: begin
        if (div_last) begin
          div_d = 8'd0;
          if (cnt_q == QUIET_LAST) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + BW'(1);
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ADC_AVG4_EN
  // Accumulate four frames per channel; publish the truncated average on the fourth.
  always_comb begin
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    frm_d   = frm_q;
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    valid_d = 1'b0;
    sum_a   = acc_a_q + {2'b00, sh_a_q};
    sum_b   = acc_b_q + {2'b00, sh_b_q};
    if (load) begin
      if (frm_q == 2'd3) begin
        a_out_d = sum_a[13:2];
        b_out_d = sum_b[13:2];
        valid_d = 1'b1;
        acc_a_d = 14'd0;
        acc_b_d = 14'd0;
        frm_d   = 2'd0;
      end else begin
        acc_a_d = sum_a;
        acc_b_d = sum_b;
        frm_d   = frm_q + 2'd1;
      end
    end
  end
`else
  // Every completed frame updates the outputs directly.
  always_comb begin
    a_out_d = a_out_q;
    b_out_d = b_out_q;
    valid_d = load;
    if (load) begin
      a_out_d = sh_a_q;
      b_out_d = sh_b_q;
    end
  end
`endif

  // State and output registers; reset returns the ADC interface to idle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      cnt_q     <= '0;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      a_out_q   <= 12'd0;
      b_out_q   <= 12'd0;
      sh_a_q    <= 12'd0;
      sh_b_q    <= 12'd0;
`ifdef ADC_AVG4_EN
      acc_a_q   <= 14'd0;
      acc_b_q   <= 14'd0;
      frm_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      a_out_q   <= a_out_d;
      b_out_q   <= b_out_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
`ifdef ADC_AVG4_EN
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      frm_q     <= frm_d;
`endif
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign valid    = valid_q;
  assign a_out    = a_out_q;
  assign b_out    = b_out_q;

endmodule

// File: tb/tb_adc_dual_capture.sv
// Bench for adc_dual_capture with CLK_DIV=2: directed frame vectors, framing
// and quiet-gap checks, overrun, asynchronous reset mid-frame, and random
// frames against a frame-level model (four-frame average when ADC_AVG4_EN).

module tb_adc_dual_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        adc_cs_n, adc_sclk;
  logic        adc_sdata_a = 1'b0;
  logic        adc_sdata_b = 1'b0;
  logic [11:0] a_out, b_out;
  logic        valid, busy, overrun;

  int total = 0;
  int bad   = 0;

  logic [15:0] word_a = 16'h0;
  logic [15:0] word_b = 16'h0;
  int          nfall  = 0;

  adc_dual_capture #(.CLK_DIV(2), .FRAME_BITS(16), .QUIET_HALVES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .adc_cs_n    (adc_cs_n),
    .adc_sclk    (adc_sclk),
    .adc_sdata_a (adc_sdata_a),
    .adc_sdata_b (adc_sdata_b),
    .a_out       (a_out),
    .b_out       (b_out),
    .valid       (valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // ADC pair model: a new frame starts on cs_n fall; next bit after each sclk fall.
  always @(negedge adc_sclk or negedge adc_cs_n) begin
    if (!adc_cs_n) begin
      if (adc_sclk) begin
        nfall = 0;
      end else begin
        #1;
        if (nfall < 16) begin
          adc_sdata_a = word_a[15 - nfall];
          adc_sdata_b = word_b[15 - nfall];
        end
        nfall = nfall + 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Pulse start, then observe one frame cycle by cycle (t=0 is the first cs_n-low cycle).
  task automatic run_frame(input logic [15:0] wa, input logic [15:0] wb, input int ovr_at,
                           output int vcnt, output int vcyc, output int csrise,
                           output int edges, output logic [11:0] ra, output logic [11:0] rb,
                           output int cs_ok, output int tmo);
    logic prev_sclk, prev_cs;
    word_a = wa;
    word_b = wb;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cs_ok = (adc_cs_n == 1'b0) ? 1 : 0;
    vcnt = 0; vcyc = -1; csrise = -1; edges = 0; ra = a_out; rb = b_out;
    prev_sclk = 1'b1;
    prev_cs = 1'b0;
    tmo = 1;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) @(negedge clk);
      if (t == ovr_at) start = 1'b1;
      else if (t == ovr_at + 1) start = 1'b0;
      if (valid) begin
        vcnt++;
        vcyc = t;
        ra = a_out;
        rb = b_out;
      end
      if (adc_sclk && !prev_sclk && !adc_cs_n) edges++;
      if (adc_cs_n && !prev_cs && csrise < 0) csrise = t;
      prev_sclk = adc_sclk;
      prev_cs = adc_cs_n;
      if (!busy) begin
        tmo = 0;
        break;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] wa;
    logic [15:0] wb;
    logic [11:0] ea;
    logic [11:0] eb;
  } vec_t;

  vec_t vecs [4];

  int vcnt, vcyc, csrise, edges, cs_ok, tmo, gap, guard;
  logic [11:0] ra, rb;

  // frame-level reference model
  int m_n;
  int m_sum_a, m_sum_b;
  int m_expv;
  int m_ea, m_eb;

  task automatic model_frame(input logic [15:0] wa, input logic [15:0] wb);
`ifdef ADC_AVG4_EN
    m_sum_a += int'(wa[11:0]);
    m_sum_b += int'(wb[11:0]);
    m_n++;
    if (m_n == 4) begin
      m_expv = 1;
      m_ea = m_sum_a / 4;
      m_eb = m_sum_b / 4;
      m_n = 0; m_sum_a = 0; m_sum_b = 0;
    end else begin
      m_expv = 0;
    end
`else
    m_expv = 1;
    m_ea = int'(wa[11:0]);
    m_eb = int'(wb[11:0]);
`endif
  endtask

  initial begin
    vecs[0] = '{16'h0FFF, 16'h0F34, 12'hFFF, 12'hF34};
    vecs[1] = '{16'hF123, 16'hF123, 12'h123, 12'h123};
    vecs[2] = '{16'h0000, 16'hFFFF, 12'h000, 12'hFFF};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 12'h5A5, 12'hA5A};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(negedge clk);

`ifndef ADC_AVG4_EN
    // directed vectors
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].wa, vecs[i].wb, -1, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
      chk($sformatf("v%0d_cs_low", i), cs_ok, 1);
      chk($sformatf("v%0d_timeout", i), tmo, 0);
      chk($sformatf("v%0d_vcount", i), vcnt, 1);
      chk($sformatf("v%0d_vcycle", i), vcyc, 65);
      chk($sformatf("v%0d_csrise", i), csrise, 66);
      chk($sformatf("v%0d_edges", i), edges, 16);
      chk($sformatf("v%0d_a", i), ra, vecs[i].ea);
      chk($sformatf("v%0d_b", i), rb, vecs[i].eb);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_a_hold", i), a_out, vecs[i].ea);
      chk($sformatf("v%0d_b_hold", i), b_out, vecs[i].eb);
    end
`endif

    // start held high: back-to-back frames and the quiet gap between them
    word_a = 16'h0123;
    word_b = 16'h0456;
    @(negedge clk);
    start = 1'b1;
    guard = 0;
    while (adc_cs_n && guard < 50) begin @(negedge clk); guard++; end
    chk("b2b_first_fall", guard < 50, 1);
    guard = 0;
    while (!adc_cs_n && guard < 200) begin @(negedge clk); guard++; end
    chk("b2b_rise", guard < 200, 1);
    gap = 0;
    while (adc_cs_n && gap < 50) begin @(negedge clk); gap++; end
    chk("b2b_gap_min4", gap >= 4, 1);
    chk("b2b_gap", gap, 5);
    start = 1'b0;
    guard = 0;
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    chk("b2b_idle", guard < 200, 1);

    // overrun
    do_reset();
    chk("ovr_initial", overrun, 0);
    run_frame(16'h0ABC, 16'h0123, 10, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
    chk("ovr_timeout", tmo, 0);
    chk("ovr_set", overrun, 1);
    chk("ovr_csrise", csrise, 66);
    chk("ovr_edges", edges, 16);
`ifndef ADC_AVG4_EN
    chk("ovr_vcycle", vcyc, 65);
    chk("ovr_a", ra, 12'hABC);
    chk("ovr_b", rb, 12'h123);
`endif
    for (int i = 0; i < 3; i++) begin
      run_frame(16'h0321, 16'h0654, -1, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
      chk($sformatf("ovr_sticky%0d", i), overrun, 1);
    end

    // asynchronous reset in the middle of SHIFT (sclk low at t=30)
    word_a = 16'h0777;
    word_b = 16'h0888;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_sclk_low", adc_sclk, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cs_n", adc_cs_n, 1);
    chk("arst_sclk", adc_sclk, 1);
    chk("arst_busy", busy, 0);
    chk("arst_a", a_out, 0);
    chk("arst_b", b_out, 0);
    chk("arst_valid", valid, 0);
    chk("arst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // random frames against the model
    do_reset();
    m_n = 0; m_sum_a = 0; m_sum_b = 0; m_expv = 0; m_ea = 0; m_eb = 0;
    for (int i = 0; i < 12; i++) begin
      logic [15:0] wa, wb;
      wa = 16'($urandom);
      wb = 16'($urandom);
      run_frame(wa, wb, -1, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
      model_frame(wa, wb);
      chk($sformatf("rnd%0d_timeout", i), tmo, 0);
      chk($sformatf("rnd%0d_vcount", i), vcnt, m_expv);
      chk($sformatf("rnd%0d_edges", i), edges, 16);
      if (m_expv == 1) begin
        chk($sformatf("rnd%0d_vcycle", i), vcyc, 65);
        chk($sformatf("rnd%0d_a", i), ra, m_ea);
        chk($sformatf("rnd%0d_b", i), rb, m_eb);
      end
    end

`ifdef ADC_AVG4_EN
    // four-frame average: A = 1,2,3,6 -> 3, B = 4 x 4 -> 4
    do_reset();
    run_frame(16'h0001, 16'h0004, -1, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
    chk("avg_f1_vcount", vcnt, 0);
    run_frame(16'h0002, 16'h0004, -1, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
    chk("avg_f2_vcount", vcnt, 0);
    run_frame(16'h0003, 16'h0004, -1, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
    chk("avg_f3_vcount", vcnt, 0);
    chk("avg_f3_a_hold", a_out, 0);
    run_frame(16'h0006, 16'h0004, -1, vcnt, vcyc, csrise, edges, ra, rb, cs_ok, tmo);
    chk("avg_f4_vcount", vcnt, 1);
    chk("avg_f4_vcycle", vcyc, 65);
    chk("avg_a", ra, 12'h003);
    chk("avg_b", rb, 12'h004);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
